// File: rtl/ALU_Package.sv
// Shared types and constants for the ALU sharing controller.
package ALU_Package;

  // ALU operation encoding; Add is the all-zero reset value.
  typedef enum logic [1:0] {
    OpAdd    = 2'd0,
    OpSub    = 2'd1,
    OpInvA   = 2'd2,
    OpRedOrB = 2'd3
  } opcode_t;

  // Controller FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } ctrl_state_t;

  // Width of the optional per-requester grant counters.
  localparam int unsigned StatsWidth = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [StatsWidth-1:0] sat_inc(input logic [StatsWidth-1:0] v);
    return (v == '1) ? v : v + StatsWidth'(1);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester and response handshake bundle for alu_share_ctrl.
interface alu_share_ctrl_if;
  import ALU_Package::*;

  logic              req0_valid;
  logic              req0_ready;
  opcode_t           req0_opcode;
  logic signed [3:0] req0_a;
  logic signed [3:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  opcode_t           req1_opcode;
  logic signed [3:0] req1_a;
  logic signed [3:0] req1_b;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic signed [4:0] resp_data;

  // Requesters plus response consumer.
  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_data
  );

  // The controller.
  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on ties, or requester 0 always wins when FIXED_PRIO != 0.
module rr_arb2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  // On a tie favour the requester that was not granted last.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = ((FIXED_PRIO != 0) || last_grant_i) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one shared, registered 4-bit ALU.
// Build macro ALU_SHARE_CTRL_STATS_EN adds saturating per-requester grant counters.
module alu_share_ctrl
  import ALU_Package::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_share_ctrl_if.slave       bus,
  output opcode_t               alu_opcode_o,
  output logic signed [3:0]     alu_a_o,
  output logic signed [3:0]     alu_b_o,
  input  logic signed [4:0]     alu_c_i,
  output logic                  busy_o
`ifdef ALU_SHARE_CTRL_STATS_EN
  ,
  output logic [StatsWidth-1:0] grant_cnt0_o,
  output logic [StatsWidth-1:0] grant_cnt1_o
`endif
);

  ctrl_state_t       state_q, state_d;
  logic              last_q;
  logic              id_q;
  opcode_t           op_q;
  logic signed [3:0] a_q, b_q;
  logic [1:0]        gnt;
  logic              accept;
  logic              resp_done;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .req_i       ({bus.req1_valid, bus.req0_valid}),
    .last_grant_i(last_q),
    .gnt_o       (gnt)
  );

  // Next-state: accept in IDLE, one fixed EXEC cycle, hold RESP until consumed.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    resp_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          accept  = 1'b1;
          state_d = StExec;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        if (bus.resp_ready) begin
          resp_done = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding registers feed the ALU so operands stay stable through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q <= 1'b0;
      op_q <= OpAdd;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      id_q <= gnt[1];
      op_q <= gnt[1] ? bus.req1_opcode : bus.req0_opcode;
      a_q  <= gnt[1] ? bus.req1_a : bus.req0_a;
      b_q  <= gnt[1] ? bus.req1_b : bus.req0_b;
    end
  end

  // Last-grant pointer moves only when a response is consumed; reset favours requester 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (resp_done) begin
      last_q <= id_q;
    end
  end

  // Readies are combinational from the grant and forced low while reset is held.
  assign bus.req0_ready = accept & gnt[0] & ~reset;
  assign bus.req1_ready = accept & gnt[1] & ~reset;
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = alu_c_i;
  assign alu_opcode_o   = op_q;
  assign alu_a_o        = a_q;
  assign alu_b_o        = b_q;
  assign busy_o         = (state_q != StIdle);

`ifdef ALU_SHARE_CTRL_STATS_EN
  logic [StatsWidth-1:0] cnt0_q, cnt1_q;

  // Saturating grant counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (gnt[0]) cnt0_q <= sat_inc(cnt0_q);
      if (gnt[1]) cnt1_q <= sat_inc(cnt1_q);
    end
  end

  assign grant_cnt0_o = cnt0_q;
  assign grant_cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural registered ALU.
module tb_alu_share_ctrl;
  import ALU_Package::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_share_ctrl_if u_if ();
  alu_share_ctrl_if fp_if ();

  opcode_t           alu_opcode, fp_opcode;
  logic signed [3:0] alu_a, alu_b, fp_a, fp_b;
  logic signed [4:0] alu_c, fp_c;
  logic              busy, fp_busy;
`ifdef ALU_SHARE_CTRL_STATS_EN
  logic [7:0] cnt0, cnt1, fp_cnt0, fp_cnt1;
`endif

  alu_share_ctrl #(.FIXED_PRIO(0)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (u_if),
    .alu_opcode_o(alu_opcode),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_c_i     (alu_c),
    .busy_o      (busy)
`ifdef ALU_SHARE_CTRL_STATS_EN
    ,
    .grant_cnt0_o(cnt0),
    .grant_cnt1_o(cnt1)
`endif
  );

  // Fixed-priority instance with both requesters permanently asserting.
  alu_share_ctrl #(.FIXED_PRIO(1)) u_dut_fp (
    .clk         (clk),
    .reset       (reset),
    .bus         (fp_if),
    .alu_opcode_o(fp_opcode),
    .alu_a_o     (fp_a),
    .alu_b_o     (fp_b),
    .alu_c_i     (fp_c),
    .busy_o      (fp_busy)
`ifdef ALU_SHARE_CTRL_STATS_EN
    ,
    .grant_cnt0_o(fp_cnt0),
    .grant_cnt1_o(fp_cnt1)
`endif
  );

  assign fp_if.req0_valid  = 1'b1;
  assign fp_if.req0_opcode = OpAdd;
  assign fp_if.req0_a      = 4'sd1;
  assign fp_if.req0_b      = 4'sd1;
  assign fp_if.req1_valid  = 1'b1;
  assign fp_if.req1_opcode = OpSub;
  assign fp_if.req1_a      = 4'sd2;
  assign fp_if.req1_b      = 4'sd1;
  assign fp_if.resp_ready  = 1'b1;

  function automatic logic signed [4:0] alu_f(input opcode_t op, input logic signed [3:0] a,
                                              input logic signed [3:0] b);
    case (op)
      OpAdd:   return {a[3], a} + {b[3], b};
      OpSub:   return {a[3], a} - {b[3], b};
      OpInvA:  return ~{a[3], a};
      default: return {4'b0000, |b};
    endcase
  endfunction

  // Registered ALU models, one cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_c <= '0;
      fp_c  <= '0;
    end else begin
      alu_c <= alu_f(alu_opcode, alu_a, alu_b);
      fp_c  <= alu_f(fp_opcode, fp_a, fp_b);
    end
  end

  int errors = 0;
  int checks = 0;
  int fp_resp = 0;
  int fp_id1 = 0;

  always @(negedge clk) begin
    if (!reset && fp_if.resp_valid && fp_if.resp_ready) begin
      fp_resp++;
      if (fp_if.resp_id) fp_id1++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input opcode_t op, input logic signed [3:0] a,
                         input logic signed [3:0] b);
    if (id) begin
      u_if.req1_valid = 1'b1; u_if.req1_opcode = op; u_if.req1_a = a; u_if.req1_b = b;
    end else begin
      u_if.req0_valid = 1'b1; u_if.req0_opcode = op; u_if.req0_a = a; u_if.req0_b = b;
    end
  endtask

  task automatic clear_reqs();
    u_if.req0_valid = 1'b0;
    u_if.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic              id;
    opcode_t           op;
    logic signed [3:0] a;
    logic signed [3:0] b;
    logic signed [4:0] exp;
  } vec_t;

  vec_t vecs[9];

  // One single-requester transaction: accept, EXEC, RESP consumed immediately.
  task automatic run_vec(input vec_t v);
    set_req(v.id, v.op, v.a, v.b);
    u_if.resp_ready = 1'b1;
    #1;
    chk("ready_own", v.id ? u_if.req1_ready : u_if.req0_ready, 1);
    chk("ready_other", v.id ? u_if.req0_ready : u_if.req1_ready, 0);
    step();
    chk("exec_busy", busy, 1);
    chk("exec_resp_valid", u_if.resp_valid, 0);
    chk("exec_alu_op", alu_opcode, v.op);
    chk("exec_alu_a", alu_a, v.a);
    chk("exec_alu_b", alu_b, v.b);
    step();
    chk("resp_valid", u_if.resp_valid, 1);
    chk("resp_data", u_if.resp_data, v.exp);
    chk("resp_id", u_if.resp_id, v.id);
    chk("resp_no_ready", v.id ? u_if.req1_ready : u_if.req0_ready, 0);
    step();
    clear_reqs();
    chk("done_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] cnt1_before;
    vecs[0] = '{1'b0, OpAdd,    4'sd3,  4'sd2,  5'sd5};
    vecs[1] = '{1'b0, OpAdd,   -4'sd8, -4'sd8, -5'sd16};
    vecs[2] = '{1'b0, OpRedOrB, 4'sd5,  4'sd0,  5'sd0};
    vecs[3] = '{1'b0, OpRedOrB, 4'sd5, -4'sd1,  5'sd1};
    vecs[4] = '{1'b1, OpSub,    4'sd7, -4'sd8,  5'sd15};
    vecs[5] = '{1'b1, OpInvA,   4'sd5,  4'sd0, -5'sd6};
    vecs[6] = '{1'b1, OpAdd,    4'sd7,  4'sd7,  5'sd14};
    vecs[7] = '{1'b0, OpSub,   -4'sd8,  4'sd7, -5'sd15};
    vecs[8] = '{1'b1, OpInvA,  -4'sd8,  4'sd3,  5'sd7};
    cnt1_before = '0;

    // Reset state, with both requesters already asserting.
    reset = 1'b1;
    u_if.resp_ready = 1'b1;
    set_req(1'b0, OpSub, 4'sd1, 4'sd1);
    set_req(1'b1, OpSub, 4'sd1, 4'sd1);
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", u_if.resp_valid, 0);
    chk("rst_ready0", u_if.req0_ready, 0);
    chk("rst_ready1", u_if.req1_ready, 0);
    chk("rst_alu_op", alu_opcode, OpAdd);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_resp_id", u_if.resp_id, 0);
    chk("rst_resp_data", u_if.resp_data, 0);
    clear_reqs();
    reset = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Round-robin contention from a fresh reset.
    do_reset();
    set_req(1'b0, OpSub, 4'sd7, -4'sd8);
    set_req(1'b1, OpInvA, 4'sd5, 4'sd0);
    #1;
    chk("rr_first_ready0", u_if.req0_ready, 1);
    chk("rr_first_ready1", u_if.req1_ready, 0);
    step();
    step();
    chk("rr_resp0_id", u_if.resp_id, 0);
    chk("rr_resp0_data", u_if.resp_data, 15);
    chk("rr_resp0_no_ready1", u_if.req1_ready, 0);
    step();
    chk("rr_second_ready1", u_if.req1_ready, 1);
    chk("rr_second_ready0", u_if.req0_ready, 0);
    step();
    step();
    chk("rr_resp1_id", u_if.resp_id, 1);
    chk("rr_resp1_data", u_if.resp_data, -6);
    clear_reqs();
    step();

    // Backpressure: RESP held for 4 cycles with both requesters pending.
    set_req(1'b0, OpAdd, -4'sd3, 4'sd5);
    u_if.resp_ready = 1'b0;
    step();
    set_req(1'b1, OpSub, 4'sd1, 4'sd1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("bp_resp_valid", u_if.resp_valid, 1);
      chk("bp_resp_data", u_if.resp_data, 2);
      chk("bp_resp_id", u_if.resp_id, 0);
      chk("bp_alu_a", alu_a, -3);
      chk("bp_alu_b", alu_b, 5);
      chk("bp_alu_op", alu_opcode, OpAdd);
      chk("bp_ready0", u_if.req0_ready, 0);
      chk("bp_ready1", u_if.req1_ready, 0);
      chk("bp_busy", busy, 1);
      step();
    end
    clear_reqs();
    u_if.resp_ready = 1'b1;
    step();
    chk("bp_released", busy, 0);

    // Reset during RESP while the pointer favours requester 1.
    set_req(1'b0, OpAdd, 4'sd1, 4'sd2);
    u_if.resp_ready = 1'b0;
    step();
    clear_reqs();
    step();
    chk("rr_resp_reached", u_if.resp_valid, 1);
    reset = 1'b1;
    set_req(1'b0, OpAdd, 4'sd1, 4'sd1);
    set_req(1'b1, OpAdd, 4'sd1, 4'sd1);
    step();
    chk("rstresp_valid", u_if.resp_valid, 0);
    chk("rstresp_busy", busy, 0);
    chk("rstresp_alu_a", alu_a, 0);
    reset = 1'b0;
    u_if.resp_ready = 1'b1;
    #1;
    chk("rstresp_ready0", u_if.req0_ready, 1);
    chk("rstresp_ready1", u_if.req1_ready, 0);
    step();
    clear_reqs();
    step();
    step();

`ifdef ALU_SHARE_CTRL_STATS_EN
    // Saturation: 300 back-to-back grants to requester 0.
    cnt1_before = cnt1;
    set_req(1'b0, OpAdd, 4'sd1, 4'sd1);
    repeat (900) step();
    clear_reqs();
    step();
    step();
    chk("stats_cnt0", cnt0, 255);
    chk("stats_cnt1", cnt1, cnt1_before);
    chk("stats_fp_cnt1", fp_cnt1, 0);
`endif

    // Fixed priority: requester 1 never served while requester 0 keeps asserting.
    chk("fp_starve_id1", fp_id1, 0);
    chk("fp_progress", int'(fp_resp > 10), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning: 0 = round-robin grant, 1 = requester 0 always wins ties.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-003 reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-004 reqN_ready  out  1  operation of requester N accepted this cycle.
REQ-005 reqN_opcode  in  opcode_t  Add/Sub/invert_A/reduction_OR_B.
REQ-006 reqN_a, reqN_b  in  4 signed  operands.
REQ-007 resp_valid  out  1; resp_ready  in  1; resp_id  out  1  granted requester; resp_data  out  5 signed  result.
REQ-008 alu_opcode  out  opcode_t; alu_a, alu_b  out  4 signed; alu_c  in  5 signed  shared ALU port (ALU_4_bit, registered output, 1-cycle latency).
REQ-009 busy  out  1  high in any state other than IDLE.

Function
REQ-010 FSM states SHALL be IDLE, EXEC, RESP.
REQ-011 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally in that cycle, capture its opcode/a/b into holding registers, go to EXEC; else stay.
REQ-012 Only one reqN_ready SHALL be high in any cycle; reqN_ready SHALL be 0 outside IDLE.
REQ-013 Round-robin: when both valid, grant the requester not granted last; after reset requester 0 has priority.
REQ-014 Priority pointer SHALL update only on completion of RESP handshake.
REQ-015 alu_opcode/alu_a/alu_b SHALL be driven from the holding registers and held stable from EXEC through the cycle RESP exits.
REQ-016 EXEC lasts exactly 1 cycle, then RESP; resp_valid SHALL rise 2 cycles after the accepting clock edge.
REQ-017 RESP: resp_valid=1, resp_data=alu_c, resp_id=granted requester; hold all three until resp_valid & resp_ready, then go to IDLE.
REQ-018 resp_data SHALL equal the ALU's 5-bit sign-extended result (Add: A+B, Sub: A-B, invert_A: ~A, reduction_OR_B: |B zero-extended); no saturation.
REQ-019 A new request SHALL not be accepted in the cycle the response completes (minimum 3 cycles per operation).
REQ-020 Request signals changing while not ready SHALL have no effect.

Reset
REQ-021 On reset in any state: state=IDLE, priority to requester 0, holding registers=0, alu_* outputs=0 (opcode Add), resp_valid=0, resp_id=0, resp_data reflects alu_c (0 under reset), busy=0, readys=0.
REQ-022 An operation in progress when reset asserts SHALL be discarded with no response.

Configuration
REQ-023 Macro ALU_SHARE_CTRL_STATS_EN: when defined, add outputs grant_cnt0, grant_cnt1 (8 bits each), incremented on each grant to that requester, saturating at 255, cleared by reset.
REQ-024 When undefined, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-025 opcode_t SHALL come from ALU_Package; state enum ctrl_state_t and the 8-bit stats width constant SHALL be added to ALU_Package.
REQ-026 Grant logic SHALL be a sub-module rr_arb2 (2 requests, last-grant input, FIXED_PRIO parameter, one-hot grant output).

Verification
REQ-027 Single op: req0 Add A=3 B=2 -> ready0 same cycle, resp_valid 2 cycles later, resp_data=5, resp_id=0.
REQ-028 Contention: both valid after reset, req0 Sub 7,-8 and req1 invert_A 5 -> first resp id0 data=15, then id1 data=-6; with FIXED_PRIO=1 and req0 re-asserting, req1 starves.
REQ-029 Width: Add -8,-8 -> -16; reduction_OR_B B=0 -> 0, B=-1 -> 1.
REQ-030 Backpressure: resp_ready low 4 cycles -> resp_valid/data/id and alu_* stable, both readys 0, busy 1.
REQ-031 Reset in RESP -> next cycle resp_valid=0, busy=0, pending req1 then granted to req0 first if both valid.
REQ-032 With ALU_SHARE_CTRL_STATS_EN: 300 grants to req0 -> grant_cnt0=255, grant_cnt1 unchanged.
